// File: rtl/ripple_pkg.sv
// ----------------------------------------------------------------------------
// ripple_pkg
// Purpose : constants shared by the ripple counter and anything that
//           instantiates it.
// Contents: DEFAULT_WIDTH - default number of counter stages.
// ----------------------------------------------------------------------------
package ripple_pkg;

   localparam int DEFAULT_WIDTH = 4;

endpackage : ripple_pkg

// File: rtl/ripple_counter_t_ff.sv
// ----------------------------------------------------------------------------
// t_ff
// Purpose : negative-edge triggered toggle flip-flop with asynchronous,
//           active-low clear. One stage of the ripple counter.
// Ports   :
//   q     out  current stage value
//   t     in   toggle enable; q flips on a clk falling edge when t is 1
//   clk   in   stage clock (falling edge active)
//   rst_n in   asynchronous active-low clear, dominates any clk edge
// ----------------------------------------------------------------------------
module t_ff (
   output logic q,
   input  logic t,
   input  logic clk,
   input  logic rst_n
);

   logic q_q;
   logic q_d;

   assign q_d = q_q ^ t;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : t_ff

// File: rtl/ripple_counter.sv
// ----------------------------------------------------------------------------
// ripple_counter
// Purpose : asynchronous (ripple) up-counter built from a chain of toggle
//           flip-flops. Q increments by one, modulo 2^WIDTH, on every falling
//           edge of CLOCK. Q may show intermediate codes while a carry ripples
//           through the chain; sample it only after it settles.
// Parameters:
//   WIDTH  number of stages (>= 1)
// Ports   :
//   Q      out  WIDTH  current count, Q[0] is the LSB
//   CLOCK  in   1      count clock, falling edge active
//   RESET  in   1      asynchronous active-low clear of every stage
// ----------------------------------------------------------------------------
module ripple_counter
   import ripple_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   output logic [WIDTH-1:0] Q,
   input  logic             CLOCK,
   input  logic             RESET
);

   // Clock seen by each stage: stage 0 runs from CLOCK, every later stage
   // from the output of the stage below it, so a 1->0 transition of Q[i-1]
   // (a carry out of the lower bits) toggles Q[i].
   logic [WIDTH-1:0] stage_clk;

   assign stage_clk[0] = CLOCK;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      if (gi > 0) begin : g_carry_clk
         assign stage_clk[gi] = Q[gi-1];
      end

      t_ff u_t_ff (
         .q     (Q[gi]),
         .t     (1'b1),
         .clk   (stage_clk[gi]),
         .rst_n (RESET)
      );
   end

endmodule : ripple_counter

// File: tb/tb_ripple_counter.sv
// ----------------------------------------------------------------------------
// tb_ripple_counter
// Directed bench for ripple_counter. A 4-bit and a 1-bit instance share
// CLOCK and RESET. CLOCK starts at 0 and toggles every 10 time units, so
// falling edges land at t = 20, 40, 60, ...
// ----------------------------------------------------------------------------
module tb_ripple_counter;

   logic       CLOCK;
   logic       RESET;
   logic [3:0] q4;
   logic [0:0] q1;

   int n_assert;
   int n_fail;

   ripple_counter #(.WIDTH(4)) dut (
      .Q     (q4),
      .CLOCK (CLOCK),
      .RESET (RESET)
   );

   ripple_counter #(.WIDTH(1)) dut_w1 (
      .Q     (q1),
      .CLOCK (CLOCK),
      .RESET (RESET)
   );

   initial CLOCK = 1'b0;
   always #10 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s at t=%0t: observed %0h expected %0h",
                tag, $time, obs, exp);
      end
      $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
   endtask

   // Wait for the next falling edge and let the ripple settle.
   task automatic fall_settle();
      @(negedge CLOCK);
      #1;
   endtask

   // Wait for the next rising edge and sample just after it.
   task automatic rise_settle();
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      logic [3:0] held;
      n_assert = 0;
      n_fail   = 0;

      // Power-up reset: drive a clean 1->0 on RESET right away.
      RESET = 1'b1;
      #1 RESET = 1'b0;
      #1;
      check("por_q4", {28'd0, q4}, 32'd0);
      check("por_q1", {31'd0, q1}, 32'd0);

      // Falling edge at t=20 while in reset is ignored.
      fall_settle();
      check("rst_edge20_q4", {28'd0, q4}, 32'd0);

      // Release at t=34: no change on release.
      #13 RESET = 1'b1;
      #1;
      check("release_q4", {28'd0, q4}, 32'd0);

      // Ten falling edges t=40..220, with rising-edge immunity checks.
      for (int k = 1; k <= 10; k++) begin
         fall_settle();
         check("cnt1_q4", {28'd0, q4}, 32'(k));
         check("cnt1_q1", {31'd0, q1}, 32'(k % 2));
         held = q4;
         rise_settle();
         check("rise1_q4", {28'd0, q4}, {28'd0, 4'(k)});
      end

      // Async reset at t=234, between clock edges.
      #3 RESET = 1'b0;
      #1;
      check("async_rst_q4", {28'd0, q4}, 32'd0);
      check("async_rst_q1", {31'd0, q1}, 32'd0);

      // Falling edges at 240, 260, 280 are ignored while in reset.
      for (int k = 0; k < 3; k++) begin
         fall_settle();
         check("hold_rst_q4", {28'd0, q4}, 32'd0);
      end

      // Second release at t=284; count 1..5 on edges 300..380.
      #3 RESET = 1'b1;
      #1;
      check("release2_q4", {28'd0, q4}, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         fall_settle();
         check("cnt2_q4", {28'd0, q4}, 32'(k));
         check("cnt2_q1", {31'd0, q1}, 32'(k % 2));
      end

      // Wrap-around: clear at t=384, release at t=390, then 17 edges.
      #3 RESET = 1'b0;
      #1;
      check("rst3_q4", {28'd0, q4}, 32'd0);
      #5 RESET = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         fall_settle();
         check("wrap_q4", {28'd0, q4}, 32'(k % 16));
         check("wrap_q1", {31'd0, q1}, 32'(k % 2));
         held = q4;
         rise_settle();
         check("wrap_rise_q4", {28'd0, q4}, 32'(k % 16));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule : tb_ripple_counter

// File: doc/ripple_counter.md
Name: ripple_counter

Overview:
- Asynchronous (ripple) up-counter built from a chain of toggle flip-flops.
- Stage 0 is clocked by the falling edge of CLOCK; each later stage is clocked by the falling edge of the previous stage's output.
- Serves as a simple event or clock-division counter, with Q exposed for monitoring.
- An asynchronous active-low reset clears all stages.

Parameters:
- WIDTH, 4, number of counter stages (width of Q); legal values are 1 or more.

Ports:
- CLOCK  input  1  count clock; stage 0 toggles on each falling edge.
- RESET  input  1  asynchronous, active-low clear; 0 forces Q to 0 immediately.
- Q  output  WIDTH  current count; Q[0] is the LSB.
- Port order in the module header is Q, CLOCK, RESET.

Behaviour:
- Reset:
  - When RESET is 0, every stage clears to 0 asynchronously, with no dependence on CLOCK. Q becomes 0 in the same time step.
  - While RESET is 0, Q holds 0 and CLOCK edges are ignored.
- Release: RESET rising 0->1 does not change Q. The first increment occurs on the first CLOCK falling edge strictly after release.
- Stage 0: Q[0] toggles on every CLOCK negedge (T input tied to 1).
- Stage i (i ≥ 1): Q[i] toggles on every negedge of Q[i-1] (T tied to 1).
- Net effect: Q increments by 1, modulo 2^WIDTH, per CLOCK falling edge.
- CLOCK rising edges have no effect.
- Wrap: from all-ones the next falling edge gives all-zeros; for WIDTH=4, 1111 -> 0000. There is no carry-out and no saturation.
- Ripple transients:
  - Intermediate codes may appear briefly during carry propagation, e.g. 0111 -> 0110 -> 0100 -> 0000 -> 1000.
  - In zero-delay simulation Q settles within the same time step as the CLOCK edge.
  - Consumers must sample Q only after settling, not on the CLOCK edge itself.
- Reset mid-count: asserting RESET at any time, including between CLOCK edges, clears Q at once. Reset dominates any edge arriving in the same time step.
- X handling: before the first RESET assertion Q is undefined. Benches must apply reset first.
- No enable, load or direction inputs. Up-counting only.

Decomposition:
- Shared package ripple_pkg holds the constant DEFAULT_WIDTH = 4. No typedefs are needed.
- One sub-module, t_ff:
  - Ports: q (out), t (in), clk (in), rst_n (in).
  - Negative-edge triggered toggle flip-flop with asynchronous active-low clear.
  - On a clk falling edge, q <= q ^ t.
- ripple_counter instantiates WIDTH copies of t_ff in a generate loop. Stage 0 clk is CLOCK; stage i clk is Q[i-1]; all rst_n inputs are tied to RESET; all t inputs are 1.

Test Plan:
All scenarios use CLOCK starting at 0 and toggling every 10 time units, so falling edges fall at t = 20, 40, 60, …
- Power-up reset: RESET=0 from t=0 to 34 -> Q=0000 throughout, including at the t=20 falling edge.
- Count after release: RESET=1 at t=34 -> Q=0001 at t=40, 0010 at 60, 0011 at 80. At t=220 Q=1010 (10 edges).
- Async reset mid-count: RESET=0 at t=234 (no CLOCK edge) -> Q=0000 at t=234. Q stays 0000 at the t=240, 260 and 280 falling edges.
- Second release: RESET=1 at t=284 -> Q=0001 at t=300, 0010 at 320, continuing to 0101 at t=380.
- Wrap-around: after release, apply 15 falling edges -> Q=1111. The 16th edge gives Q=0000 and the 17th gives 0001. Check that every stage toggles on its predecessor's falling edge.
- Rising-edge immunity / WIDTH=1 corner:
  - Q is unchanged on every CLOCK rising edge.
  - With WIDTH=1, Q alternates 0,1,0 on successive falling edges after release.
